trace_collector: RTL and testbench

Consumer side of the trace filter. Each cycle it takes the CPU trace entry (PC + instruction) together with the filter's `drop_instr` verdict. Kept entries are tagged with the number of instructions dropped since the previous kept entry, then buffered in a FIFO. The FIFO drains to the host over a valid/ready stream, so control-flow history can be reconstructed from the gaps.

---
 rtl/trace_collector_if.sv | 15 +
 rtl/trace_collector.sv | 76 +++++++
 tb/tb_trace_collector.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/trace_collector_if.sv
// Trace collector stream bundle: trace entries in, packed kept entries out to the host.
interface trace_collector_if #(parameter int PC_WIDTH = 64);
  logic                   in_valid;
  logic [PC_WIDTH-1:0]    in_pc;
  logic [31:0]            in_instr;
  logic                   drop_instr;
  logic                   out_valid;
  logic                   out_ready;
  logic [PC_WIDTH+63:0]   out_data;

  modport master (output in_valid, in_pc, in_instr, drop_instr, out_ready,
                  input  out_valid, out_data);
  modport slave  (input  in_valid, in_pc, in_instr, drop_instr, out_ready,
                  output out_valid, out_data);
endinterface

// File: rtl/trace_collector.sv
// Tags kept trace entries with the count of dropped instructions since the last
// kept one and buffers them in a FIFO drained over a valid/ready stream.
module trace_collector #(
  parameter int FIFO_DEPTH = 16,
  parameter int PC_WIDTH   = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  trace_collector_if.slave              bus,
  output logic [$clog2(FIFO_DEPTH):0]   occupancy,
  output logic [31:0]                   lost_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [31:0]         instr;
    logic [15:0]         skip;
    logic [14:0]         zero;
    logic                ovf;
  } entry_t;

  entry_t         mem [FIFO_DEPTH];
  entry_t         entry;
  logic [AW-1:0]  rd_ptr, wr_ptr;
  logic [15:0]    skip_cnt;
  logic           ovf_pending;
  logic           q, keep, pop, push, reject;

  assign q      = en & bus.in_valid;
  assign keep   = q & ~bus.drop_instr;
  assign pop    = bus.out_valid & bus.out_ready;
  // A full FIFO still takes the push when the head leaves in the same cycle.
  assign push   = keep & ((occupancy < DEPTH_C) | pop);
  assign reject = keep & ~push;

  assign entry = '{pc: bus.in_pc, instr: bus.in_instr, skip: skip_cnt,
                   zero: '0, ovf: ovf_pending};

  assign bus.out_valid = (occupancy != '0);
  assign bus.out_data  = bus.out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      occupancy   <= '0;
      lost_count  <= '0;
      skip_cnt    <= '0;
      ovf_pending <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      occupancy <= occupancy + 1'b1;
      else if (!push && pop) occupancy <= occupancy - 1'b1;

      if (push) begin
        skip_cnt    <= '0;
        ovf_pending <= 1'b0;
      end else if (q && (bus.drop_instr || reject)) begin
        // A lost kept entry is reported to the host as one more skipped instruction.
        if (skip_cnt != 16'hFFFF) skip_cnt <= skip_cnt + 16'd1;
      end
      if (reject) begin
        ovf_pending <= 1'b1;
        if (lost_count != 32'hFFFF_FFFF) lost_count <= lost_count + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_trace_collector.sv
// Self-checking bench for trace_collector: vector table, directed corner cases,
// and randomized traffic against a queue-based reference model.
module tb_trace_collector;
  localparam int DEPTH = 16;
  localparam int PCW   = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [4:0]  occupancy;
  logic [31:0] lost_count;

  trace_collector_if #(.PC_WIDTH(PCW)) tif ();

  trace_collector #(.FIFO_DEPTH(DEPTH), .PC_WIDTH(PCW)) dut (
    .clk(clk), .rst(rst), .en(en), .bus(tif),
    .occupancy(occupancy), .lost_count(lost_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  logic [127:0] mq[$];
  logic [15:0]  m_skip;
  bit           m_ovf;
  logic [31:0]  m_lost;
  logic [127:0] delivered[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] mk(input logic [63:0] pc, input logic [31:0] ins,
                                      input logic [15:0] sk, input bit ov);
    return {pc, ins, sk, 15'b0, ov};
  endfunction

  task automatic model_check();
    chk("occupancy", 128'(occupancy), 128'(mq.size()));
    chk("out_valid", 128'(tif.out_valid), 128'(mq.size() != 0));
    chk("out_data", tif.out_data, (mq.size() != 0) ? mq[0] : 128'b0);
    chk("lost_count", 128'(lost_count), 128'(m_lost));
  endtask

  task automatic model_clear();
    mq.delete();
    m_skip = '0;
    m_ovf  = 1'b0;
    m_lost = '0;
  endtask

  // drive one cycle, advance the model, compare after the edge
  task automatic cyc(input bit e, input bit v, input bit d, input bit r,
                     input logic [63:0] pc, input logic [31:0] ins);
    bit pop, full, qual;
    en = e; tif.in_valid = v; tif.drop_instr = d; tif.out_ready = r;
    tif.in_pc = pc; tif.in_instr = ins;
    if (tif.out_valid && r) delivered.push_back(tif.out_data);
    pop  = (mq.size() != 0) && r;
    full = (mq.size() == DEPTH);
    qual = e && v;
    if (pop) void'(mq.pop_front());
    if (qual) begin
      if (d) begin
        if (m_skip != 16'hFFFF) m_skip++;
      end else if (!full || pop) begin
        mq.push_back(mk(pc, ins, m_skip, m_ovf));
        m_skip = '0;
        m_ovf  = 1'b0;
      end else begin
        if (m_lost != 32'hFFFF_FFFF) m_lost++;
        m_ovf = 1'b1;
        if (m_skip != 16'hFFFF) m_skip++;
      end
    end
    @(posedge clk); #1;
    model_check();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; en = 1'b0; tif.in_valid = 1'b0; tif.drop_instr = 1'b0; tif.out_ready = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
    delivered.delete();
    chk("reset_valid", 128'(tif.out_valid), 128'(0));
    chk("reset_occ", 128'(occupancy), 128'(0));
    chk("reset_lost", 128'(lost_count), 128'(0));
    chk("reset_data", tif.out_data, 128'(0));
  endtask

  typedef struct {
    bit          v;
    bit          d;
    logic [63:0] pc;
    logic [31:0] ins;
    bit          ev;
    logic [15:0] eskip;
    int          eocc;
  } vec_t;

  localparam logic [31:0] INS32 = 32'h0000_0013;
  localparam logic [31:0] INS16 = 32'hDEAD_4501;

  initial begin
    vec_t tbl[12];
    logic [127:0] exp_d;
    tif.in_valid = 1'b0; tif.in_pc = '0; tif.in_instr = '0;
    tif.drop_instr = 1'b0; tif.out_ready = 1'b0;

    // basic stream and skip counting
    tbl[0]  = '{1, 0, 64'h1000, INS32, 1, 16'd0, 1};
    tbl[1]  = '{1, 0, 64'h1004, INS16, 1, 16'd0, 1};
    tbl[2]  = '{1, 0, 64'h1008, INS32, 1, 16'd0, 1};
    tbl[3]  = '{0, 0, 64'h0,    INS32, 0, 16'd0, 0};
    for (int i = 4; i < 9; i++) tbl[i] = '{1, 1, 64'h1800 + 64'(4*i), INS32, 0, 16'd0, 0};
    tbl[9]  = '{1, 0, 64'h2000, INS32, 1, 16'd5, 1};
    tbl[10] = '{1, 0, 64'h2004, INS16, 1, 16'd0, 1};
    tbl[11] = '{0, 0, 64'h0,    INS32, 0, 16'd0, 0};

    do_reset(2);
    for (int i = 0; i < 12; i++) begin
      cyc(1, tbl[i].v, tbl[i].d, 1, tbl[i].pc, tbl[i].ins);
      exp_d = tbl[i].ev ? mk(tbl[i].pc, tbl[i].ins, tbl[i].eskip, 1'b0) : 128'b0;
      chk($sformatf("vec%0d_valid", i), 128'(tif.out_valid), 128'(tbl[i].ev));
      chk($sformatf("vec%0d_data", i), tif.out_data, exp_d);
      chk($sformatf("vec%0d_occ", i), 128'(occupancy), 128'(tbl[i].eocc));
    end

    // overflow: 18 kept into a 16-deep FIFO, then release with one more
    do_reset(1);
    for (int i = 0; i < 18; i++) cyc(1, 1, 0, 0, 64'h3000 + 64'(4*i), INS32);
    chk("ovf_occ", 128'(occupancy), 128'(16));
    chk("ovf_lost", 128'(lost_count), 128'(2));
    cyc(1, 1, 0, 1, 64'h3100, INS16);
    chk("ovf_pushpop_occ", 128'(occupancy), 128'(16));
    chk("ovf_pushpop_lost", 128'(lost_count), 128'(2));
    repeat (20) cyc(1, 0, 0, 1, 64'h0, INS32);
    chk("ovf_count", 128'(delivered.size()), 128'(17));
    for (int i = 0; i < 16 && i < delivered.size(); i++)
      chk($sformatf("ovf_order%0d", i), 128'(delivered[i][127:64]), 128'(64'h3000 + 64'(4*i)));
    if (delivered.size() > 16) chk("ovf_tagged", delivered[16], mk(64'h3100, INS16, 16'd2, 1'b1));

    // full with simultaneous push and pop
    delivered.delete();
    for (int i = 0; i < 16; i++) cyc(1, 1, 0, 0, 64'h4000 + 64'(4*i), INS32);
    chk("full_occ", 128'(occupancy), 128'(16));
    cyc(1, 1, 0, 1, 64'h4100, INS32);
    chk("full_pp_occ", 128'(occupancy), 128'(16));
    chk("full_pp_lost", 128'(lost_count), 128'(2));
    repeat (20) cyc(1, 0, 0, 1, 64'h0, INS32);
    chk("full_count", 128'(delivered.size()), 128'(17));
    if (delivered.size() > 16) chk("full_last", delivered[16], mk(64'h4100, INS32, 16'd0, 1'b0));

    // enable gating holds skip count, then saturation
    repeat (3) cyc(1, 1, 1, 1, 64'h4800, INS32);
    for (int i = 0; i < 10; i++) cyc(0, 1, i[0], 1, 64'h4900 + 64'(4*i), INS32);
    chk("en_occ", 128'(occupancy), 128'(0));
    cyc(1, 1, 0, 1, 64'h5000, INS32);
    chk("en_held_skip", tif.out_data, mk(64'h5000, INS32, 16'd3, 1'b0));
    for (int i = 0; i < 70000; i++) cyc(1, 1, 1, 1, 64'h6000, INS32);
    cyc(1, 1, 0, 1, 64'h5100, INS32);
    chk("sat_skip", tif.out_data, mk(64'h5100, INS32, 16'hFFFF, 1'b0));
    cyc(1, 0, 0, 1, 64'h0, INS32);

    // reset mid-stream with 7 entries buffered and nonzero lost count
    for (int i = 0; i < 20; i++) cyc(1, 1, 0, 0, 64'h7000 + 64'(4*i), INS32);
    repeat (9) cyc(1, 0, 0, 1, 64'h0, INS32);
    chk("mid_occ", 128'(occupancy), 128'(7));
    do_reset(1);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit r;
      r = ((i / 64) % 3 == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 3, r,
          {$urandom, $urandom}, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
